div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits downstream of the register file: the execute stage hands it the two source-register read values and the destination address. It returns the result on a write port that plugs directly into the register file's write-enable, write-address and write-data inputs. It uses a restoring algorithm that retires one quotient bit per cycle, with a busy/done handshake so the pipeline can stall while it runs.

## Interface
Parameters:
- XLEN, default `CPU_WIDTH` (32): operand and result width.
- AW, default `REG_ADDR_WIDTH` (5): register address width.

Ports:
- clk  in  1  core clock. Reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  XLEN  rs1 read data.
- divisor  in  XLEN  rs2 read data.
- rd_addr  in  AW  destination register.
- flush  in  1  abort any operation in flight.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- reg_wen  out  1  register write enable, equal to done && (reg_waddr != 0).
- reg_waddr  out  AW  latched rd_addr.
- reg_wdata  out  XLEN  result.

## Operation
- States:
  - IDLE to CALC on start && !flush. On that edge the unit latches op and rd_addr, the operand signs, |dividend| and |divisor|, and clears the quotient, partial remainder and a 6-bit counter.
  - CALC: each cycle shifts the next dividend bit into the remainder, trial-subtracts the divisor and sets the quotient bit if the result is non-negative. The counter increments. After XLEN iterations the state moves to DONE.
  - DONE: outputs the result for one cycle, then returns to IDLE.
- Absolute values are used for signed ops (DIV, REM) only. |0x80000000| is 0x80000000 treated as unsigned, with no overflow.
- Sign fix-up in DONE:
  - Quotient is negated iff the ops are signed, the operand signs differ, and divisor != 0.
  - Remainder is negated iff the ops are signed and the dividend is negative.
- Divide by zero gives quotient 0xFFFFFFFF and remainder equal to the dividend. Both fall out of the restoring loop plus the fix-up rules; there is no special result path.
- Overflow (0x80000000 / 0xFFFFFFFF, DIV) gives quotient 0x80000000 and remainder 0, with no special case.
- start while busy is ignored. No queueing.
- flush in any state forces IDLE on the next edge and suppresses the write. flush beats a simultaneous start.
- rd_addr == 0: done still pulses and reg_wen stays low.

## Timing
- Reset (rst_n low at an edge): state IDLE, and busy, done, reg_wen, reg_waddr and reg_wdata all 0. This takes effect mid-operation too, with no write.
- All outputs are registered.
- start accepted at edge N:
  - busy = 1 from N+1.
  - CALC occupies N+1 to N+XLEN.
  - DONE at N+XLEN+1 (N+33), where done, reg_wen and reg_wdata are valid.
  - busy falls and IDLE is reached at N+34. The earliest next start is sampled at edge N+34.
- reg_wdata and reg_waddr hold their last values after DONE.
- done is a single-cycle pulse.

## Configuration
- DIV_FAST_ZERO_EN:
  - Defined: if divisor == 0 at acceptance, the FSM goes directly from IDLE to DONE, so done arrives at N+1. The result is identical to the full-loop result.
  - Undefined: divide by zero runs the full XLEN iterations, like any other operands.

## Structure
- defines.v gains:
  - the op encodings DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU;
  - the FSM encodings DIV_ST_IDLE, DIV_ST_CALC, DIV_ST_DONE.
- Sub-module div_step (combinational): takes the remainder, the next dividend bit and the divisor. It returns the new remainder and the quotient bit. It is instantiated once.

## Test plan
- DIVU 100 / 7, rd = 5, start at N → at N+33: done = 1, reg_wen = 1, reg_waddr = 5, reg_wdata = 14. Same operands with REMU → 2. busy is high from N+1 to N+33.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- DIVU 5 / 0 → 0xFFFFFFFF. REM 0xFFFFFFFB / 0 → 0xFFFFFFFB. Completion is at N+33 without DIV_FAST_ZERO_EN and at N+1 with it.
- Flush and reset mid-operation:
  - start at N, flush at N+10 → busy = 0 at N+11, and reg_wen never rises. A new start at N+11 is accepted.
  - rst_n low mid-CALC gives the same outcome.
- Rejected starts and x0 destination:
  - A second start pulse at N+5 while busy is ignored, so only one done is produced.
  - A DIVU with rd = 0 pulses done with reg_wen = 0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared widths plus the operation and FSM encodings for the RV32M divider.
package div_unit_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial difference when it does not go negative.
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quo_o
);

    logic [XLEN:0] shifted;

    // Remainder stays below the divisor, so the kept difference fits in XLEN bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        quo_o   = (shifted >= {1'b0, divisor_i});
        rem_o   = quo_o ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a register-file write port.
// Optional DIV_FAST_ZERO_EN: a zero divisor skips the iteration loop and completes next cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH,
    parameter int AW   = REG_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [AW-1:0]   rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            reg_wen,
    output logic [AW-1:0]   reg_waddr,
    output logic [XLEN-1:0] reg_wdata
);

    // state       | meaning
    // DIV_ST_IDLE | waiting for start
    // DIV_ST_CALC | one quotient bit per cycle, XLEN cycles
    // DIV_ST_DONE | result on the write port for one cycle

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [XLEN-1:0] step_rem;
    logic            step_quo;
    logic            sgn, dvd_neg, dsr_neg;
    logic [XLEN-1:0] abs_dvd, abs_dsr;
    logic [XLEN-1:0] quo_raw, quo_fin, rem_fin;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .bit_i     (acc_q[XLEN-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        sgn     = op_is_signed(op);
        dvd_neg = sgn & dividend[XLEN-1];
        dsr_neg = sgn & divisor[XLEN-1];
        abs_dvd = dvd_neg ? -dividend : dividend;
        abs_dsr = dsr_neg ? -divisor : divisor;
        // acc holds the unconsumed dividend bits on top and the quotient below
        quo_raw = {acc_q[XLEN-2:0], step_quo};
        quo_fin = neg_quo_q ? -quo_raw : quo_raw;
        rem_fin = neg_rem_q ? -step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        case (state_q)
            DIV_ST_IDLE: begin
                busy_d = 1'b0;
                if (start && !flush) begin
                    acc_d     = abs_dvd;
                    dsr_d     = abs_dsr;
                    rem_d     = '0;
                    cnt_d     = '0;
                    is_rem_d  = op_is_rem(op);
                    neg_quo_d = sgn & (dividend[XLEN-1] ^ divisor[XLEN-1]) & (divisor != '0);
                    neg_rem_d = dvd_neg;
                    rd_d      = rd_addr;
                    busy_d    = 1'b1;
                    state_d   = DIV_ST_CALC;
`ifdef DIV_FAST_ZERO_EN
                    if (divisor == '0) begin
                        state_d = DIV_ST_DONE;
                        done_d  = 1'b1;
                        wen_d   = (rd_addr != '0);
                        waddr_d = rd_addr;
                        wdata_d = op_is_rem(op) ? dividend : '1;
                    end
`endif
                end
            end
            DIV_ST_CALC: begin
                rem_d = step_rem;
                acc_d = quo_raw;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN - 1)) begin
                    state_d = DIV_ST_DONE;
                    done_d  = 1'b1;
                    wen_d   = (rd_q != '0);
                    waddr_d = rd_q;
                    wdata_d = is_rem_q ? rem_fin : quo_fin;
                end
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = DIV_ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (flush) begin
            state_d = DIV_ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            wen_d   = 1'b0;
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= DIV_ST_IDLE;
            acc_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_wen   = wen_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, latency, flush, reset and x0 handling.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy;
    logic        done;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int wen_cnt  = 0;

`ifdef DIV_FAST_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .rd_addr   (rd_addr),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .reg_wen   (reg_wen),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (reg_wen) wen_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat);
        int k;
        logic busy_ok;
        op = o; dividend = a; divisor = b; rd_addr = rd; start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        while (!done && k < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_held"}, {31'd0, busy_ok & busy}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_wdata"}, reg_wdata, exp_data);
        check({tag, "_waddr"}, {27'd0, reg_waddr}, {27'd0, rd});
        check({tag, "_wen"}, {31'd0, reg_wen}, {31'd0, rd != 5'd0});
        tick();
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_wdata_hold"}, reg_wdata, exp_data);
    endtask

    initial begin
        int d0;
        int w0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = 2'b00; dividend = '0; divisor = '0; rd_addr = '0;
        tick();
        tick();
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_wen",   {31'd0, reg_wen}, 32'd0);
        check("rst_waddr", {27'd0, reg_waddr}, 32'd0);
        check("rst_wdata", reg_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("divu_100_7",   2'b01, 32'd100,      32'd7,        5'd5,  32'd14,       33);
        run_op("remu_100_7",   2'b11, 32'd100,      32'd7,        5'd5,  32'd2,        33);
        run_op("div_m7_2",     2'b00, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 33);
        run_op("rem_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 33);
        run_op("div_7_m2",     2'b00, 32'd7,        32'hFFFFFFFE, 5'd8,  32'hFFFFFFFD, 33);
        run_op("rem_7_m2",     2'b10, 32'd7,        32'hFFFFFFFE, 5'd8,  32'd1,        33);
        run_op("div_ovf",      2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 33);
        run_op("rem_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'd0,        33);
        run_op("remu_big",     2'b11, 32'hFFFFFFFF, 32'h00000010, 5'd10, 32'h0000000F, 33);
        run_op("divu_5_0",     2'b01, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, ZERO_LAT);
        run_op("rem_m5_0",     2'b10, 32'hFFFFFFFB, 32'd0,        5'd12, 32'hFFFFFFFB, ZERO_LAT);
        run_op("div_min_0",    2'b00, 32'h80000000, 32'd0,        5'd13, 32'hFFFFFFFF, ZERO_LAT);
        run_op("divu_rd0",     2'b01, 32'd100,      32'd7,        5'd0,  32'd14,       33);

        // flush at cycle N+10, then a start right in the next cycle
        d0 = done_cnt; w0 = wen_cnt;
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd_addr = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_no_done", 32'(done_cnt - d0), 32'd0);
        check("flush_no_wen", 32'(wen_cnt - w0), 32'd0);
        run_op("after_flush", 2'b01, 32'd1000, 32'd10, 5'd4, 32'd100, 33);

        // flush beats a simultaneous start
        op = 2'b01; dividend = 32'd9; divisor = 32'd3; rd_addr = 5'd2;
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        tick();
        check("flush_start_idle", {31'd0, busy}, 32'd0);

        // reset mid-CALC
        d0 = done_cnt; w0 = wen_cnt;
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; rd_addr = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy",  {31'd0, busy}, 32'd0);
        check("midrst_waddr", {27'd0, reg_waddr}, 32'd0);
        check("midrst_wdata", reg_wdata, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_wen", 32'(wen_cnt - w0), 32'd0);
        run_op("after_rst", 2'b11, 32'd1000, 32'd7, 5'd1, 32'd6, 33);

        // second start while busy is ignored
        d0 = done_cnt;
        op = 2'b01; dividend = 32'd1000; divisor = 32'd10; rd_addr = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        op = 2'b11; dividend = 32'd9; divisor = 32'd4; rd_addr = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 45; i++) tick();
        check("busy_start_ignored", 32'(done_cnt - d0), 32'd1);
        check("busy_start_wdata", reg_wdata, 32'd100);
        check("busy_start_waddr", {27'd0, reg_waddr}, 32'd7);
        check("busy_start_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
